// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline buffer between two stages: DEPTH-entry FIFO with valid/ready
// on both sides, synchronous flush, optional empty-bypass and a saturating stall counter.
module pipe_stage_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic          BYPASS_EN  = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_stall_cycles;

    logic w_empty;
    logic w_full;
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_store;
    logic w_advance_rd;
    logic w_stall;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // Reset gates the handshake so nothing appears live while the buffer is held.
    assign w_in_ready  = !reset && !flush && !w_full;
    assign w_out_valid = !reset && !flush && (!w_empty || (BYPASS_EN && in_valid));

    assign w_push = in_valid && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    // A bypassed entry is consumed in flight and never touches storage or pointers.
    assign w_bypass     = BYPASS_EN && w_empty && w_push && out_ready;
    assign w_store      = w_push && !w_bypass;
    assign w_advance_rd = w_pop && !w_bypass;

    assign w_stall = w_out_valid && !out_ready;

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = (BYPASS_EN && w_empty) ? in_data : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_advance_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_store && !w_advance_rd) begin
                r_count <= r_count + CW'(1);
            end else if (w_advance_rd && !w_store) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Payload storage is deliberately left unreset; out_data is ignored while out_valid is low.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Only reset clears the stall statistic; flush keeps the history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: three instances cover DEPTH=2/BYPASS=0,
// DEPTH=4/BYPASS=0 and DEPTH=2/BYPASS=1.
module tb_pipe_stage_fifo;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Instance A: DEPTH=2, BYPASS=0
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_count;
    logic [31:0] a_stall;

    // Instance B: DEPTH=4, BYPASS=0
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_count;
    logic [31:0] b_stall;

    // Instance C: DEPTH=2, BYPASS=1
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [15:0] c_in_data, c_out_data;
    logic [1:0]  c_count;
    logic [31:0] c_stall;

    pipe_stage_fifo #(.WIDTH(16), .DEPTH(2), .BYPASS(0)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .count(a_count), .stall_cycles(a_stall)
    );

    pipe_stage_fifo #(.WIDTH(16), .DEPTH(4), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .count(b_count), .stall_cycles(b_stall)
    );

    pipe_stage_fifo #(.WIDTH(16), .DEPTH(2), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .flush(c_flush), .count(c_count), .stall_cycles(c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_in_data = '0;
        b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_in_data = '0;
        c_in_valid = 1; c_out_ready = 0; c_flush = 0; c_in_data = 16'h1234;
        step();
        step();
        checks++; if (a_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (c_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_bypass_out_valid got=%b exp=0", c_out_valid); end
        checks++; if (a_stall !== 32'd0) begin failures++; $display("[TB] FAIL reset_stall got=%0d exp=0", a_stall); end
        reset = 1'b0;
        c_in_valid = 0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", a_in_ready); end
        step();
    endtask

    task automatic test_fill_drain();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h00A1;
        step();
        a_in_data = 16'h00B2;
        step();
        checks++; if (a_count !== 2'd2) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=2", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_in_ready got=%b exp=0", a_in_ready); end
        a_in_data = 16'h00C3;
        step();
        checks++; if (a_count !== 2'd2) begin failures++; $display("[TB] FAIL full_refuse_count got=%0d exp=2", a_count); end
        checks++; if (a_out_data !== 16'h00A1) begin failures++; $display("[TB] FAIL full_head got=%h exp=00a1", a_out_data); end
        a_out_ready = 1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_in_ready got=%b exp=0", a_in_ready); end
        step();
        checks++; if (a_count !== 2'd1) begin failures++; $display("[TB] FAIL drain1_count got=%0d exp=1", a_count); end
        checks++; if (a_out_data !== 16'h00B2) begin failures++; $display("[TB] FAIL drain1_data got=%h exp=00b2", a_out_data); end
        step();
        checks++; if (a_count !== 2'd1) begin failures++; $display("[TB] FAIL drain2_count got=%0d exp=1", a_count); end
        checks++; if (a_out_data !== 16'h00C3) begin failures++; $display("[TB] FAIL drain2_data got=%h exp=00c3", a_out_data); end
        a_in_valid = 0;
        step();
        checks++; if (a_count !== 2'd0) begin failures++; $display("[TB] FAIL drain3_count got=%0d exp=0", a_count); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain3_out_valid got=%b exp=0", a_out_valid); end
        a_out_ready = 0;
    endtask

    task automatic test_wrap();
        int  sent;
        int  rcvd;
        logic push;
        logic pop;
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
            b_in_valid  = (sent < 10);
            b_in_data   = 16'(sent);
            b_out_ready = (cyc % 2 == 0);
            #1;
            push = b_in_valid && b_in_ready;
            pop  = b_out_valid && b_out_ready;
            if (pop) begin
                checks++;
                if (b_out_data !== 16'(rcvd)) begin failures++; $display("[TB] FAIL wrap_data idx=%0d got=%0d exp=%0d", rcvd, b_out_data, rcvd); end
                rcvd++;
            end
            checks++;
            if (b_count > 3'd4) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp<=4", b_count); end
            @(posedge clk);
            #1;
            if (push) sent++;
        end
        b_in_valid = 0;
        b_out_ready = 0;
        checks++; if (rcvd !== 10) begin failures++; $display("[TB] FAIL wrap_total got=%0d exp=10", rcvd); end
        checks++; if (b_count !== 3'd0) begin failures++; $display("[TB] FAIL wrap_end_count got=%0d exp=0", b_count); end
    endtask

    task automatic test_bypass();
        c_in_valid = 1; c_in_data = 16'hDEAD; c_out_ready = 1;
        #1;
        checks++; if (c_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bypass_out_valid got=%b exp=1", c_out_valid); end
        checks++; if (c_out_data !== 16'hDEAD) begin failures++; $display("[TB] FAIL bypass_data got=%h exp=dead", c_out_data); end
        step();
        checks++; if (c_count !== 2'd0) begin failures++; $display("[TB] FAIL bypass_count got=%0d exp=0", c_count); end
        c_in_data = 16'hBEEF; c_out_ready = 0;
        #1;
        checks++; if (c_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bypass_stall_out_valid got=%b exp=1", c_out_valid); end
        step();
        checks++; if (c_count !== 2'd1) begin failures++; $display("[TB] FAIL bypass_store_count got=%0d exp=1", c_count); end
        c_in_valid = 0;
        #1;
        checks++; if (c_out_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL bypass_store_data got=%h exp=beef", c_out_data); end
        c_out_ready = 1;
        step();
        checks++; if (c_count !== 2'd0) begin failures++; $display("[TB] FAIL bypass_drain_count got=%0d exp=0", c_count); end
        c_out_ready = 0;
    endtask

    task automatic test_flush();
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h0111;
        step();
        a_in_data = 16'h0222;
        step();
        checks++; if (a_count !== 2'd2) begin failures++; $display("[TB] FAIL flush_pre_count got=%0d exp=2", a_count); end
        a_flush = 1; a_in_valid = 1; a_in_data = 16'h0333; a_out_ready = 1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid got=%b exp=0", a_out_valid); end
        step();
        checks++; if (a_count !== 2'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", a_count); end
        a_flush = 0; a_in_data = 16'h0777; a_out_ready = 0;
        step();
        a_in_valid = 0;
        #1;
        checks++; if (a_count !== 2'd1) begin failures++; $display("[TB] FAIL flush_post_count got=%0d exp=1", a_count); end
        checks++; if (a_out_data !== 16'h0777) begin failures++; $display("[TB] FAIL flush_post_data got=%h exp=0777", a_out_data); end
        a_out_ready = 1;
        step();
        a_out_ready = 0;
    endtask

    task automatic test_async_reset();
        a_in_valid = 1; a_in_data = 16'h0A0A; a_out_ready = 0;
        step();
        a_in_data = 16'h0B0B;
        step();
        a_in_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_count !== 2'd0) begin failures++; $display("[TB] FAIL async_count got=%0d exp=0", a_count); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_stall !== 32'd0) begin failures++; $display("[TB] FAIL async_stall got=%0d exp=0", a_stall); end
        step();
    endtask

    task automatic test_stall();
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h0C0C;
        step();
        a_in_valid = 0;
        #1;
        checks++; if (a_out_data !== 16'h0C0C) begin failures++; $display("[TB] FAIL reset_first_push got=%h exp=0c0c", a_out_data); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (a_stall !== 32'd5) begin failures++; $display("[TB] FAIL stall_five got=%0d exp=5", a_stall); end
        a_flush = 1;
        step();
        a_flush = 0;
        #1;
        checks++; if (a_stall !== 32'd5) begin failures++; $display("[TB] FAIL stall_after_flush got=%0d exp=5", a_stall); end
        checks++; if (a_count !== 2'd0) begin failures++; $display("[TB] FAIL stall_flush_count got=%0d exp=0", a_count); end
    endtask

    task automatic test_saturation();
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h0D0D;
        step();
        a_in_valid = 0;
        force u_a.r_stall_cycles = 32'hFFFF_FFFD;
        #1;
        release u_a.r_stall_cycles;
        step();
        checks++; if (a_stall !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL sat_step got=%h exp=fffffffe", a_stall); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (a_stall !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_hold got=%h exp=ffffffff", a_stall); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_bypass();
        test_flush();
        test_async_reset();
        test_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
